// File: rtl/matrix_operand_loader_pkg.sv
// Shared constants, state encoding and beat type for the 4x4 matrix operand loader.
// Elements are packed r*DIM+c, ELEM_W bits each, LSB-first.
package matrix_pkg;

    localparam int DIM      = 4;
    localparam int ELEM_W   = 3;
    localparam int N_ELEM   = 2 * DIM * DIM;
    localparam int RES_W    = 8;
    localparam int BANK_N   = DIM * DIM;
    localparam int IDX_W    = $clog2(BANK_N);
    localparam int CNT_W    = $clog2(N_ELEM);
    localparam int FLAT_W   = BANK_N * ELEM_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    typedef struct packed {
        logic [ELEM_W-1:0] data;
        logic              last;
    } beat_t;

    function automatic int flat_lsb(input int r, input int c);
        return (r * DIM + c) * ELEM_W;
    endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Element stream in, held operand set out. The loader uses the slave modport.
interface matrix_operand_loader_if;
    import matrix_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [FLAT_W-1:0] a_flat;
    logic [FLAT_W-1:0] b_flat;
    logic              err_len;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, a_flat, b_flat, err_len
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, a_flat, b_flat, err_len
    );

endinterface

// File: rtl/matrix_operand_loader_elem_bank.sv
// 16-entry element register bank with a single write port and a flat read bus.
module mat_elem_bank
    import matrix_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [ELEM_W-1:0] wdata_i,
    output logic [FLAT_W-1:0] rd_flat_o
);

    logic [BANK_N-1:0][ELEM_W-1:0] mem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rd_flat_o = mem_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Collects a 32-element serial frame (A then B, row-major) and holds it on flat
// buses until the downstream multiplier takes it; flags frame-length violations.
module matrix_operand_loader
    import matrix_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    matrix_operand_loader_if.slave   bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, out_valid_q, err_q, err_d;
    logic              wr_en;
    logic [1:0]        bank_we;
    logic [1:0][FLAT_W-1:0] bank_rd;
    beat_t             beat;

    assign beat = '{data: bus.in_data, last: bus.in_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == FULL);
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        bank_we = '0;
        case (state_q)
            INIT: state_d = LOAD;
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    if (beat.last && cnt_q != LAST_IDX) begin
                        // Early last: drop the beat and restart the frame.
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_d = FULL;
                            cnt_d   = '0;
                            err_d   = ~beat.last;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            FULL: if (bus.out_ready) state_d = LOAD;
            default: state_d = INIT;
        endcase
        bank_we[cnt_q[CNT_W-1]] = wr_en;
    end

    // Bank 0 holds A (indices 0-15), bank 1 holds B (indices 16-31).
    for (genvar b = 0; b < 2; b++) begin : g_bank
        mat_elem_bank u_bank (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .we_i      (bank_we[b]),
            .widx_i    (cnt_q[IDX_W-1:0]),
            .wdata_i   (beat.data),
            .rd_flat_o (bank_rd[b])
        );
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_len   = err_q;
    assign bus.a_flat    = bank_rd[0];
    assign bus.b_flat    = bank_rd[1];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Random-gap stream bench for matrix_operand_loader with an element-array reference model.
module tb_matrix_operand_loader;
    import matrix_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   err_seen = 0;

    matrix_operand_loader_if bus();

    matrix_operand_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: expected 32-element register image plus handshake flags.
    bit [2:0] m_mem [32];
    int       m_cnt = 0;
    bit       m_rdy = 0, m_vld = 0, m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            m_cnt <= 0; m_rdy <= 0; m_vld <= 0; m_err <= 0;
        end else begin
            m_err <= 0;
            if (m_vld) begin
                if (bus.out_ready) begin m_vld <= 0; m_rdy <= 1; end
            end else if (!m_rdy) begin
                m_rdy <= 1;
            end else if (bus.in_valid) begin
                if (bus.in_last && m_cnt < 31) begin
                    m_cnt <= 0; m_err <= 1;
                end else begin
                    m_mem[m_cnt] <= bus.in_data;
                    if (m_cnt == 31) begin
                        m_cnt <= 0; m_vld <= 1; m_rdy <= 0; m_err <= !bus.in_last;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            end
        end
    end

    function automatic logic [47:0] model_flat(input int base);
        logic [47:0] f = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f[(r*4+c)*3 +: 3] = m_mem[base + r*4 + c];
        return f;
    endfunction

    function automatic logic [47:0] pat_mod8(input int base);
        logic [47:0] f = '0;
        for (int i = 0; i < 16; i++) f[i*3 +: 3] = 3'((base + i) % 8);
        return f;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.err_len === 1'b1) err_seen++;
        chk("in_ready",  48'(bus.in_ready),  48'(m_rdy));
        chk("out_valid", 48'(bus.out_valid), 48'(m_vld));
        chk("err_len",   48'(bus.err_len),   48'(m_err));
        chk("a_flat",    bus.a_flat, model_flat(0));
        chk("b_flat",    bus.b_flat, model_flat(16));
    end

    task automatic send_beat(input logic [2:0] d, input logic l, input int gap);
        int t;
        while (gap > 0 && $urandom_range(99) < gap) begin
            bus.in_valid = 0;
            @(negedge clk);
        end
        bus.in_valid = 1; bus.in_data = d; bus.in_last = l;
        t = 0;
        while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_chk++; n_err++;
            $display("FAIL beat_timeout act=in_ready_low exp=accept t=%0t", $time);
        end
        @(negedge clk);
        bus.in_valid = 0; bus.in_last = 0;
    endtask

    // mode 0: idx%8, 1: all 5, 2: random
    task automatic send_frame(input int mode, input int gap, input int stop_at, input bit last_ok);
        logic [2:0] d;
        for (int i = 0; i <= stop_at; i++) begin
            d = (mode == 0) ? 3'(i % 8) : (mode == 1) ? 3'd5 : 3'($urandom_range(7));
            send_beat(d, (i == stop_at) ? last_ok : 1'b0, gap);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1;
        @(negedge clk);
        bus.out_ready = 0;
        chk("hs_out_valid_drop", 48'(bus.out_valid), 48'd0);
        chk("hs_in_ready",       48'(bus.in_ready),  48'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst_n = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.out_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 48'(bus.in_ready), 48'd0);
        chk("rst_a_flat",   bus.a_flat, 48'd0);
        rst_n = 1;
        #1 chk("post_rst_in_ready0", 48'(bus.in_ready), 48'd0);
        @(negedge clk);
        chk("post_rst_in_ready1", 48'(bus.in_ready), 48'd1);
        chk("idle_out_valid",     48'(bus.out_valid), 48'd0);

        // Full frame, gap-free, then hold
        send_frame(0, 0, 31, 1);
        chk("lat_out_valid", 48'(bus.out_valid), 48'd1);
        chk("a00", 48'(bus.a_flat[2:0]),   48'd0);
        chk("a33", 48'(bus.a_flat[47:45]), 48'd7);
        chk("b00", 48'(bus.b_flat[2:0]),   48'd0);
        chk("b01", 48'(bus.b_flat[5:3]),   48'd1);
        repeat (10) begin
            @(negedge clk);
            chk("hold_a", bus.a_flat, pat_mod8(0));
            chk("hold_b", bus.b_flat, pat_mod8(16));
            chk("hold_in_ready", 48'(bus.in_ready), 48'd0);
        end

        // Handshake then back-to-back all-5 frame
        handshake();
        send_frame(1, 0, 31, 1);
        chk("all5_a", bus.a_flat, {16{3'd5}});
        chk("all5_b", bus.b_flat, {16{3'd5}});
        handshake();

        // Random gaps: same content as the gap-free run
        send_frame(0, 50, 31, 1);
        chk("gap_valid", 48'(bus.out_valid), 48'd1);
        chk("gap_a", bus.a_flat, pat_mod8(0));
        chk("gap_b", bus.b_flat, pat_mod8(16));
        handshake();

        // Early last at idx 9, then clean random frame
        e0 = err_seen;
        send_frame(2, 30, 9, 1);
        repeat (2) @(negedge clk);
        chk("early_err_once",  48'(err_seen - e0), 48'd1);
        chk("early_out_valid", 48'(bus.out_valid), 48'd0);
        send_frame(2, 30, 31, 1);
        chk("after_early_valid", 48'(bus.out_valid), 48'd1);
        handshake();

        // Missing last at idx 31
        e0 = err_seen;
        send_frame(0, 0, 31, 0);
        chk("miss_valid", 48'(bus.out_valid), 48'd1);
        @(negedge clk);
        chk("miss_err_once", 48'(err_seen - e0), 48'd1);
        chk("miss_a", bus.a_flat, pat_mod8(0));
        handshake();

        // Async reset mid-frame
        send_frame(1, 0, 11, 0);
        #2 rst_n = 0;
        #1;
        chk("arst_in_ready",  48'(bus.in_ready),  48'd0);
        chk("arst_out_valid", 48'(bus.out_valid), 48'd0);
        chk("arst_err",       48'(bus.err_len),   48'd0);
        chk("arst_a",         bus.a_flat, 48'd0);
        chk("arst_b",         bus.b_flat, 48'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream feeder for the 4x4 parallel matrix multiplier (3-bit unsigned elements, 8-bit results).
- Accepts a serial stream of 32 elements over a valid/ready handshake: A row-major first, then B row-major.
- Holds the completed operand set stable on flat parallel buses and presents it with out_valid/out_ready.
- The downstream multiplier and result-capture stage consume the operands while they are held.

Parameters:
- DIM, 4, matrix dimension (rows = cols); only 4 is supported.
- ELEM_W, 3, element width in bits, unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  loader can accept an element.
- in_data  in  ELEM_W  element value.
- in_last  in  1  marks the final (32nd) element of a frame.
- out_valid  out  1  complete operand set held on a_flat/b_flat.
- out_ready  in  1  downstream accepts the operand set.
- a_flat  out  DIM*DIM*ELEM_W (48)  A[r][c] at bits [(r*4+c)*3 +: 3].
- b_flat  out  DIM*DIM*ELEM_W (48)  B[r][c] at bits [(r*4+c)*3 +: 3].
- err_len  out  1  one-cycle pulse on a frame-length violation.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous, active-low.
  - On rst_n low: state = INIT, cnt = 0, in_ready = 0, out_valid = 0, err_len = 0, all 32 element registers = 0.
  - All outputs are registered.
- Beat accept: a beat is accepted when in_valid & in_ready at a rising edge.
- States:
  - INIT: in_ready = 0. Goes to LOAD on the next clock, unconditionally.
  - LOAD: in_ready = 1, out_valid = 0.
    - Each accepted beat writes in_data to element index cnt, then cnt increments.
    - Indices 0-15 go to A[cnt/4][cnt%4]; indices 16-31 go to B[(cnt-16)/4][cnt%4].
    - A beat accepted at cnt = 31 goes to FULL; in_ready = 0 and out_valid = 1 from the next cycle.
  - FULL: in_ready = 0, out_valid = 1, and a_flat/b_flat do not change.
    - When out_ready = 1 at a clock: out_valid = 0 and in_ready = 1 next cycle; state goes to LOAD with cnt = 0.
    - The element registers keep their values until overwritten.
    - No beat is accepted in the handshake cycle.
- Latency and throughput:
  - Last beat accepted at cycle N gives out_valid = 1 at cycle N+1.
  - Minimum frame period is 33 cycles: 32 beats plus one FULL cycle with out_ready = 1.
- Length checking:
  - Early last: in_last = 1 on an accepted beat with cnt < 31.
    - That beat is discarded and cnt returns to 0 (frame aborted); err_len pulses next cycle.
    - Partially written registers are overwritten by the next frame. out_valid stays 0.
  - Missing last: in_last = 0 on the beat accepted at cnt = 31.
    - The frame still completes and goes to FULL; err_len pulses next cycle.
- Stalls: in_valid low mid-frame stalls without losing cnt. out_ready may stay low indefinitely; the outputs are held.
- Reset mid-frame or while FULL: immediate return to the reset values; the partial frame is lost.
- Arithmetic: no arithmetic on data; elements pass through unmodified.
  - cnt is 5 bits and never wraps past 31; the transition to FULL resets it.

Decomposition:
- Shared package matrix_pkg:
  - DIM = 4, ELEM_W = 3, N_ELEM = 2*DIM*DIM = 32, RES_W = 8.
  - State enum {INIT, LOAD, FULL}.
  - Flat-index helper constants for the r*DIM+c packing.
- One sub-module, mat_elem_bank:
  - 16 x ELEM_W register bank with async-low reset, write enable and 4-bit write index, flat read bus.
  - Instantiated twice (A and B); write enable is selected by cnt[4].

Test Plan:
- Reset then idle:
  - in_ready = 0 during reset and in the first cycle after release, then 1.
  - out_valid = 0; a_flat = b_flat = 0.
- Full frame:
  - Stream values idx%8 for idx 0..31, in_last on idx 31, out_ready = 0.
  - out_valid rises the cycle after beat 31.
  - a_flat[2:0] = 0, a_flat[47:45] = 7, b_flat[2:0] = 0 (idx 16), b_flat[5:3] = 1; outputs stable for 10 held cycles.
- Handshake and back-to-back:
  - Assert out_ready one cycle, then stream a second frame of all 5s immediately.
  - out_valid drops next cycle; in_ready = 1; after 32 more beats a_flat = b_flat = {16{3'd5}}.
- Random in_valid gaps (50%):
  - Frame content is identical to the gap-free run, with no dropped or duplicated elements.
- Early last at idx 9:
  - err_len pulses once; out_valid stays 0.
  - A subsequent clean 32-beat frame loads correctly from index 0.
- Missing last at idx 31:
  - err_len pulses; out_valid = 1 with correct data.
  - Asserting rst_n = 0 mid-way through the following frame returns all outputs to their reset values asynchronously.
